// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared definitions for the ALU request sequencer: FSM state encoding,
//   op-code boundary constants and the per-op latency helper.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Highest legal op; anything above gets an error response.
  localparam logic [3:0] OP_MAX      = 4'd9;
  // First op that runs on a multi-cycle ALU unit.
  localparam logic [3:0] OP_MC_FIRST = 4'd8;

  // Cycles spent in EXEC for a legal op.
  function automatic int unsigned op_latency(input logic [3:0] op,
                                             input int unsigned mc_lat);
    return (op >= OP_MC_FIRST) ? mc_lat : 32'd1;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Accepts one ALU request at a time, drives the latched operands and the
//   result-mux select to the externally instantiated ALU units, waits the
//   op's latency, captures the mux output and presents it as a response.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_op, req_a, req_b   op code (legal 0..9) and operands
//   op_a, op_b             latched operands to every ALU unit
//   selec_alu              select for the 10-input result mux (never > 9)
//   alu_result             mux output, sampled on the last EXEC cycle
//   rsp_valid/rsp_ready    response handshake
//   rsp_result, rsp_err    captured result, illegal-op flag
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N      = 4,
  parameter int MC_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  output logic [N-1:0] op_a,
  output logic [N-1:0] op_b,
  output logic [3:0]   selec_alu,
  input  logic [N-1:0] alu_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_err
);

  localparam int CW = $clog2(MC_LAT + 1);

  state_e         r_state;
  logic [CW-1:0]  r_cnt;
  logic [3:0]     r_sel;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_result;
  logic           r_err;

  logic           w_op_legal;
  logic [CW-1:0]  w_cnt_load;

  assign w_op_legal = (req_op <= OP_MAX);
  // Counter holds "cycles remaining after this one", so load latency-1.
  assign w_cnt_load = CW'(op_latency(req_op, MC_LAT) - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_sel    <= 4'd0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            if (w_op_legal) begin
              r_sel   <= req_op;
              r_a     <= req_a;
              r_b     <= req_b;
              r_cnt   <= w_cnt_load;
              r_state <= ST_EXEC;
            end else begin
              // Illegal op: leave select/operands alone so the mux input
              // stays on a driven unit; answer immediately with an error.
              r_result <= '0;
              r_err    <= 1'b1;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            r_result <= alu_result;
            r_err    <= 1'b0;
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign rsp_valid  = (r_state == ST_DONE);
  assign selec_alu  = r_sel;
  assign op_a       = r_a;
  assign op_b       = r_b;
  assign rsp_result = r_result;
  assign rsp_err    = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Randomized bench for alu_sequencer (N=4, MC_LAT=3). Models the parent's
//   ALU units + result mux, and predicts each response (value, error flag,
//   latency) directly from the request.
module tb_alu_sequencer;

  localparam int N      = 4;
  localparam int MC_LAT = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_op = 4'd0;
  logic [N-1:0] req_a = '0;
  logic [N-1:0] req_b = '0;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [3:0]   selec_alu;
  logic [N-1:0] alu_result;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [N-1:0] rsp_result;
  logic         rsp_err;

  int total = 0;
  int bad   = 0;

  // Reference view of what select/operands should currently hold.
  logic [3:0]   mdl_sel;
  logic [N-1:0] mdl_a;
  logic [N-1:0] mdl_b;

  always #5 clk = ~clk;

  alu_sequencer #(.N(N), .MC_LAT(MC_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .op_a(op_a), .op_b(op_b), .selec_alu(selec_alu),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err)
  );

  // The ten ALU units behind the parent's mux.
  function automatic logic [N-1:0] alu_fn(input logic [3:0] sel,
                                          input logic [N-1:0] a,
                                          input logic [N-1:0] b);
    case (sel)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~a;
      4'd6: return a << 1;
      4'd7: return a >> 1;
      4'd8: return a * b;
      4'd9: return a + b + 1'b1;
      default: return 'x;
    endcase
  endfunction

  always_comb alu_result = alu_fn(selec_alu, op_a, op_b);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Entry and exit: just after a negedge with the DUT idle.
  task automatic do_txn(input logic [3:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b, input int hold);
    logic         legal;
    logic [N-1:0] exp_res;
    int           exp_lat;
    int           cyc;
    logic         got;
    legal   = (op <= 4'd9);
    exp_res = legal ? alu_fn(op, a, b) : '0;
    exp_lat = !legal ? 1 : ((op >= 4'd8) ? MC_LAT + 1 : 2);

    check("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk);
    if (legal) begin
      mdl_sel = op; mdl_a = a; mdl_b = b;
    end
    cyc = 0; got = 1'b0;
    while (cyc < 40 && !got) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        check("ready_busy", req_ready, 0);
        if (legal) check("sel_exec", selec_alu, op);
        // Ignored while busy.
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 4'($urandom_range(0, 15));
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
    check("rsp_latency", cyc, exp_lat);
    $display("txn op=%0d a=%0d b=%0d lat=%0d res=%0d err=%0d hold=%0d",
             op, a, b, cyc, rsp_result, rsp_err, hold);
    if (!got) return;
    check("rsp_result", rsp_result, exp_res);
    check("rsp_err", rsp_err, !legal);
    check("sel_done", selec_alu, mdl_sel);
    check("op_a_done", op_a, mdl_a);
    check("op_b_done", op_b, mdl_b);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_op    = 4'($urandom_range(0, 9));
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_ready", req_ready, 0);
      check("hold_result", rsp_result, exp_res);
      check("hold_err", rsp_err, !legal);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1;   // must not be taken in the handshake cycle
    req_op    = 4'($urandom_range(0, 9));
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_valid", rsp_valid, 0);
    check("post_ready", req_ready, 1);
    check("post_sel", selec_alu, mdl_sel);
  endtask

  initial begin
    mdl_sel = 4'd0; mdl_a = '0; mdl_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", req_ready, 1);
    check("rst_valid", rsp_valid, 0);
    check("rst_sel", selec_alu, 0);
    check("rst_op_a", op_a, 0);
    check("rst_result", rsp_result, 0);
    check("rst_err", rsp_err, 0);

    do_txn(4'd2, 4'd5, 4'd3, 0);
    do_txn(4'd8, 4'd3, 4'd4, 0);
    do_txn(4'd12, 4'd7, 4'd7, 0);
    do_txn(4'd6, 4'd9, 4'd1, 5);

    // Reset on the second EXEC cycle of a multi-cycle op.
    req_valid = 1'b1; req_op = 4'd9; req_a = 4'd2; req_b = 4'd6;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_sel_exec", selec_alu, 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mdl_sel = 4'd0; mdl_a = '0; mdl_b = '0;
    $display("txn reset during EXEC of op 9");
    check("abort_valid", rsp_valid, 0);
    check("abort_ready", req_ready, 1);
    check("abort_sel", selec_alu, 0);
    check("abort_op_b", op_b, 0);
    check("abort_result", rsp_result, 0);
    do_txn(4'd1, 4'd4, 4'd9, 0);

    for (int i = 0; i < 40; i++) begin
      do_txn(4'($urandom_range(0, 15)), N'($urandom), N'($urandom),
             int'($urandom_range(0, 3)));
    end
    do_txn(4'd15, 4'd1, 4'd1, 1);
    do_txn(4'd9, 4'd15, 4'd15, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
